// File: rtl/wb_pkg.sv
// Shared types and defaults for the execute-stage writeback arbiter.
// Request bundle, grant encoding and sizing constants.
package wb_pkg;

  localparam int DATA_W         = 16;
  localparam int REG_W          = 3;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int DEF_STARVE_MAX = 3;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LDST,
    GNT_HOLD
  } grant_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Requester and register-file write-port signals of the writeback arbiter.
// slave = arbiter side, master = surrounding pipeline / regfile side.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic [REG_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              ldst_valid;
  logic [REG_W-1:0]  ldst_rd;
  logic [DATA_W-1:0] ldst_data;
  logic              ldst_ready;

  logic              rf_wr;
  logic [REG_W-1:0]  rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic              rf_wr_success;

  modport slave (
    input  alu_valid,
    input  alu_rd,
    input  alu_data,
    output alu_ready,
    input  ldst_valid,
    input  ldst_rd,
    input  ldst_data,
    output ldst_ready,
    output rf_wr,
    output rf_rd,
    output rf_data,
    input  rf_wr_success
  );

  modport master (
    output alu_valid,
    output alu_rd,
    output alu_data,
    input  alu_ready,
    output ldst_valid,
    output ldst_rd,
    output ldst_data,
    input  ldst_ready,
    input  rf_wr,
    input  rf_rd,
    input  rf_data,
    output rf_wr_success
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests with flush.
// Full/empty come from the occupancy count; pointers wrap naturally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_req_t       din,
  input  logic          pop,
  input  logic          flush,
  output wb_req_t       dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_req_t mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & !full & !flush;
  assign do_pop  = pop & !empty & !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the single regfile write port between
// the ALU (buffered) and load/store (priority) with retry on reject.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter  int ALU_FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter  int STARVE_MAX     = DEF_STARVE_MAX,
  localparam int CW             = $clog2(ALU_FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   bus,
  input  logic          flush,
  output logic [CW-1:0] fifo_count,
  output logic          busy
);

  localparam int             SW   = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  SMAX = SW'(STARVE_MAX);

  grant_e            gnt;
  wb_req_t           head;
  wb_req_t           alu_req;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              port_free;
  logic              starved;
  logic              alu_sel;
  logic              ldst_sel;
  logic [SW-1:0]     starve;
  logic              wr_q;
  logic [REG_W-1:0]  rd_q;
  logic [DATA_W-1:0] data_q;

  assign alu_req       = '{rd: bus.alu_rd, data: bus.alu_data};
  assign bus.alu_ready = !full;
  assign push          = bus.alu_valid & !full;
  assign pop           = (gnt == GNT_ALU);

  wb_fifo #(
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (alu_req),
    .pop   (pop),
    .flush (flush),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign port_free = !wr_q | bus.rf_wr_success;
  assign starved   = (starve == SMAX);
  // The ALU head stays put during a flush cycle.
  assign alu_sel   = port_free & !empty & !flush
                   & (!bus.ldst_valid | starved);
  assign ldst_sel  = port_free & bus.ldst_valid & !alu_sel;

  always_comb begin
    gnt = GNT_NONE;
    unique case (1'b1)
      !port_free: gnt = GNT_HOLD;
      alu_sel:    gnt = GNT_ALU;
      ldst_sel:   gnt = GNT_LDST;
      default:    gnt = GNT_NONE;
    endcase
  end

  assign bus.ldst_ready = (gnt == GNT_LDST) & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      unique case (gnt)
        GNT_ALU: begin
          wr_q   <= 1'b1;
          rd_q   <= head.rd;
          data_q <= head.data;
        end
        GNT_LDST: begin
          wr_q   <= 1'b1;
          rd_q   <= bus.ldst_rd;
          data_q <= bus.ldst_data;
        end
        GNT_NONE: wr_q <= 1'b0;
        GNT_HOLD: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= '0;
    end else if (flush || empty || gnt == GNT_ALU) begin
      starve <= '0;
    end else if (gnt == GNT_LDST && !starved) begin
      starve <= starve + SW'(1);
    end
  end

  assign bus.rf_wr   = wr_q;
  assign bus.rf_rd   = rd_q;
  assign bus.rf_data = data_q;
  assign busy        = wr_q | (fifo_count != '0);

  hold_stable: assert property (
    @(posedge clk) disable iff (!rst)
    gnt == GNT_HOLD |=> wr_q && $stable(rd_q) && $stable(data_q)
  );

  alu_has_entry: assert property (
    @(posedge clk) disable iff (!rst)
    gnt == GNT_ALU |-> !empty
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter against a
// queue-based reference model of the writeback rules.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int SMAX  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] fifo_count;
  logic       busy;

  wb_arbiter_if bus();

  wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  wb_req_t     q[$];
  logic [15:0] wlog[$];
  logic        m_wr;
  logic [2:0]  m_rd;
  logic [15:0] m_data;
  int          m_st;
  logic        obs_acc;
  logic        obs_lr;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wr   = 1'b0;
    m_rd   = '0;
    m_data = '0;
    m_st   = 0;
  endtask

  task automatic idle_inputs();
    bus.alu_valid     = 1'b0;
    bus.ldst_valid    = 1'b0;
    bus.rf_wr_success = 1'b1;
    flush             = 1'b0;
  endtask

  // One clock: drive, check against model, advance model.
  task automatic step(input logic av, input logic [2:0] ard,
                      input logic [15:0] adat, input logic lv,
                      input logic [2:0] lrd, input logic [15:0] ldat,
                      input logic fl, input logic sc);
    int      g;
    bit      ar;
    bit      pf;
    wb_req_t h;
    @(negedge clk);
    bus.alu_valid     = av;
    bus.alu_rd        = ard;
    bus.alu_data      = adat;
    bus.ldst_valid    = lv;
    bus.ldst_rd       = lrd;
    bus.ldst_data     = ldat;
    flush             = fl;
    bus.rf_wr_success = sc;
    #1;
    ar = (q.size() < DEPTH);
    pf = !m_wr || sc;
    if (!pf) g = 3;
    else if (q.size() != 0 && !fl && (!lv || m_st == SMAX)) g = 1;
    else if (lv) g = 2;
    else g = 0;
    chk("rf_wr", 32'(bus.rf_wr), 32'(m_wr));
    chk("rf_rd", 32'(bus.rf_rd), 32'(m_rd));
    chk("rf_data", 32'(bus.rf_data), 32'(m_data));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("busy", 32'(busy), 32'(m_wr || q.size() != 0));
    chk("alu_ready", 32'(bus.alu_ready), 32'(ar));
    chk("ldst_ready", 32'(bus.ldst_ready), 32'(g == 2));
    obs_acc = av && bus.alu_ready;
    obs_lr  = bus.ldst_ready;
    if (bus.rf_wr && sc) wlog.push_back(bus.rf_data);
    if (fl || q.size() == 0 || g == 1) m_st = 0;
    else if (g == 2 && m_st < SMAX) m_st++;
    case (g)
      1: begin
        h = q.pop_front();
        m_wr = 1'b1; m_rd = h.rd; m_data = h.data;
      end
      2: begin
        m_wr = 1'b1; m_rd = lrd; m_data = ldat;
      end
      0: m_wr = 1'b0;
      default: ;
    endcase
    if (fl) q.delete();
    else if (av && ar) q.push_back('{rd: ard, data: adat});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic sc);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, sc);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || m_wr) && n < 30) begin
      idle(1'b1);
      n++;
    end
    chk("drain_bound", 32'(n < 30), 32'd1);
  endtask

  function automatic bit seen(input logic [15:0] v);
    foreach (wlog[i]) if (wlog[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [15:0] alu_seen[$];
    int n;
    model_reset();
    idle_inputs();
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.ldst_rd   = '0;
    bus.ldst_data = '0;
    bus.ldst_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_wr", 32'(bus.rf_wr), 32'd0);
    chk("rst_rf_rd", 32'(bus.rf_rd), 32'd0);
    chk("rst_rf_data", 32'(bus.rf_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("rst_ldst_ready", 32'(bus.ldst_ready), 32'd0);
    @(negedge clk);
    bus.ldst_valid = 1'b0;
    rst = 1'b1;

    // Single ALU write, two-cycle latency.
    step(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
    chk("alu1_count", 32'(fifo_count), 32'd1);
    idle(1'b1);
    chk("alu1_wr", 32'(bus.rf_wr), 32'd1);
    chk("alu1_rd", 32'(bus.rf_rd), 32'd3);
    chk("alu1_data", 32'(bus.rf_data), 32'h1234);
    idle(1'b1);
    chk("alu1_busy", 32'(busy), 32'd0);

    // Starvation guard: ALU wins after STARVE_MAX load wins.
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1);
    step(1'b1, 3'd1, 16'h0001, 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1);
    chk("starve_ld0", 32'(bus.rf_rd), 32'd5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1);
      chk("starve_ld", 32'(bus.rf_data), 32'hBEEF);
    end
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1);
    chk("starve_alu_rd", 32'(bus.rf_rd), 32'd1);
    chk("starve_alu_data", 32'(bus.rf_data), 32'h0001);
    drain();

    // Three back-to-back ALU pushes under load pressure.
    wlog.delete();
    step(1'b1, 3'd0, 16'h000A, 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1);
    step(1'b1, 3'd1, 16'h000B, 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1);
    chk("bb_count", 32'(fifo_count), 32'd2);
    chk("bb_full", 32'(bus.alu_ready), 32'd0);
    n = 0;
    obs_acc = 1'b0;
    while (!obs_acc && n < 10) begin
      step(1'b1, 3'd2, 16'h000C, 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1);
      n++;
    end
    chk("bb_accept_bound", 32'(obs_acc), 32'd1);
    for (int i = 0; i < 6; i++)
      step(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1);
    drain();
    foreach (wlog[i]) if (wlog[i] != 16'hBEEF) alu_seen.push_back(wlog[i]);
    chk("bb_n", 32'(alu_seen.size()), 32'd3);
    for (int i = 0; i < alu_seen.size() && i < 3; i++)
      chk("bb_order", 32'(alu_seen[i]), 32'(16'h000A + i));

    // Regfile rejects three times; port stays frozen.
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h00FF, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h1111, 1'b0, 1'b0);
      chk("rej_lr", 32'(obs_lr), 32'd0);
      chk("rej_data", 32'(bus.rf_data), 32'h00FF);
      chk("rej_rd", 32'(bus.rf_rd), 32'd2);
    end
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h1111, 1'b0, 1'b1);
    chk("rej_grant", 32'(obs_lr), 32'd1);
    chk("rej_next", 32'(bus.rf_data), 32'h1111);
    drain();

    // Flush with full FIFO, then with one entry and an accepted push.
    wlog.delete();
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h2222, 1'b0, 1'b1);
    step(1'b1, 3'd1, 16'h0101, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 3'd2, 16'h0202, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("fl_pre", 32'(fifo_count), 32'd2);
    step(1'b1, 3'd3, 16'hDEAD, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    chk("fl_count", 32'(fifo_count), 32'd0);
    chk("fl_port", 32'(bus.rf_data), 32'h2222);
    step(1'b1, 3'd1, 16'h0303, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 3'd3, 16'hDEAD, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    chk("fl2_count", 32'(fifo_count), 32'd0);
    chk("fl2_wr", 32'(bus.rf_wr), 32'd1);
    drain();
    chk("fl_inflight", 32'(seen(16'h2222)), 32'd1);
    chk("fl_dead", 32'(seen(16'hDEAD)), 32'd0);
    chk("fl_drop", 32'(seen(16'h0101)), 32'd0);

    // Asynchronous reset in the middle of a retry.
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'h3333, 1'b0, 1'b1);
    step(1'b1, 3'd1, 16'h4444, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    bus.rf_wr_success = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_wr", 32'(bus.rf_wr), 32'd0);
    chk("arst_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("arst_count", 32'(fifo_count), 32'd0);
    model_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 50), 3'($urandom),
           16'($urandom), 1'($urandom_range(0, 99) < 65),
           3'($urandom), 16'($urandom),
           1'($urandom_range(0, 99) < 4),
           1'($urandom_range(0, 99) < 75));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
